// File: rtl/adder_pkg.sv
// Shared types, default widths and helpers for the adder / frame accumulator slice.
package adder_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  localparam int ADD_N     = 8;
  localparam int ADD_ACC_W = 16;
  localparam int ADD_CNT_W = 8;

  // Working width of the sign-extension helper; callers slice down to their own width.
  localparam int ADD_EXT_W = 64;

  // Replicate bit (width-1) of value into every higher bit position.
  function automatic logic [ADD_EXT_W-1:0] sign_extend(input logic [ADD_EXT_W-1:0] value,
                                                       input int width);
    logic [ADD_EXT_W-1:0] result;
    result = value;
    for (int i = 0; i < ADD_EXT_W; i++) begin
      if (i >= width) result[i] = value[width-1];
    end
    return result;
  endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Combinational n-bit ripple-carry adder with carry in and carry out.
module n_bit_adder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] carry;

  // Ripple chain: each bit's carry out feeds the next bit's carry in.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < n; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[n];

endmodule

// File: rtl/frame_accumulator.sv
// Sums a framed stream of signed operands into a wider signed accumulator and
// presents total, operand count and sticky overflow on a valid/ready port.
module frame_accumulator
  import adder_pkg::*;
#(
  parameter int N     = ADD_N,
  parameter int ACC_W = ADD_ACC_W,
  parameter int CNT_W = ADD_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  acc_state_t                  state;
  logic signed [ACC_W-1:0]     acc;
  logic        [CNT_W-1:0]     cnt;
  logic                        ovf;

  logic signed [ACC_W-1:0]     operand;
  logic signed [ACC_W-1:0]     sum_next;
  logic [ADD_EXT_W-ACC_W-1:0]  ext_hi_unused;
  logic                        cout_unused;
  logic [CNT_W-1:0]            cnt_next;
  logic                        ovf_now;
  logic                        accept;

  // Operand widened to the accumulator width; bits above ACC_W are not needed.
  assign {ext_hi_unused, operand} =
    sign_extend({{(ADD_EXT_W - N){1'b0}}, in_data}, N);

  n_bit_adder #(.n(ACC_W)) u_adder (
    .a    (acc),
    .b    (operand),
    .cin  (1'b0),
    .sum  (sum_next),
    .cout (cout_unused)
  );

  // Signed overflow: addends agree in sign but the wrapped result does not.
  assign ovf_now = (acc[ACC_W-1] == operand[ACC_W-1]) &&
                   (sum_next[ACC_W-1] != acc[ACC_W-1]);

  // Operand count sticks at its maximum rather than wrapping.
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  assign accept = in_valid && in_ready;

  // Frame FSM: accumulate in ACC, publish and wait for the consumer in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= sum_next;
            cnt <= cnt_next;
            ovf <= ovf | ovf_now;
            if (in_last) begin
              // Publish totals that already include this closing operand.
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= sum_next;
              out_count <= cnt_next;
              out_ovf   <= ovf | ovf_now;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            // Result consumed: start the next frame from a clean accumulator.
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: a 16-bit and an 8-bit accumulator driven in lockstep,
// directed frames followed by randomized frames against an arithmetic reference model.
module tb_frame_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [15:0] out_sum_w;
  logic [7:0]  out_count_w;

  logic        in_ready_n, out_valid_n, out_ovf_n;
  logic [7:0]  out_sum_n;
  logic [2:0]  out_count_n;

  int tests_run;
  int tests_failed;

  frame_accumulator #(.N(8), .ACC_W(16), .CNT_W(8)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_sum   (out_sum_w),
    .out_count (out_count_w),
    .out_ovf   (out_ovf_w)
  );

  frame_accumulator #(.N(8), .ACC_W(8), .CNT_W(3)) dut_narrow (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_n),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_n),
    .out_ready (out_ready),
    .out_sum   (out_sum_n),
    .out_count (out_count_n),
    .out_ovf   (out_ovf_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted beat: entered and left on a falling edge.
  task automatic beat(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reduce an exact integer to a w-bit two's complement value.
  function automatic longint wrap(input longint t, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = t % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint t, input int w);
    longint lim;
    lim = longint'(1) << (w - 1);
    return (t >= lim) || (t < -lim);
  endfunction

  typedef struct {
    longint sum_w;
    longint sum_n;
    longint cnt_w;
    longint cnt_n;
    logic   ovf_w;
    logic   ovf_n;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  longint total, run_w, run_n, x;
  logic   ovf_w_m, ovf_n_m;
  int     len, pos, gen, done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got %0d frames, expected %0d", done, 200);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done         = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    out_ready    = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_in_ready", in_ready_w, 1);
    check("rst_out_valid", out_valid_w, 0);
    check("rst_sum", out_sum_w, 0);
    check("rst_count", out_count_w, 0);
    check("rst_ovf", out_ovf_w, 0);
    rst_n = 1'b1;

    // Basic frame 10, 8, 5
    beat(8'd10, 1'b0);
    beat(8'd8, 1'b0);
    beat(8'd5, 1'b1);
    check("t1_valid", out_valid_w, 1);
    check("t1_sum", out_sum_w, 23);
    check("t1_count", out_count_w, 3);
    check("t1_ovf", out_ovf_w, 0);
    check("t1_in_ready_hold", in_ready_w, 0);
    next_cycle();
    check("t1_in_ready_back", in_ready_w, 1);
    check("t1_valid_low", out_valid_w, 0);

    // Signed frame -128, 127, -1
    beat(8'h80, 1'b0);
    beat(8'h7F, 1'b0);
    beat(8'hFF, 1'b1);
    check("t2_sum", out_sum_w, 16'hFFFE);
    check("t2_count", out_count_w, 3);
    check("t2_ovf", out_ovf_w, 0);
    next_cycle();

    // Overflow on the 8-bit accumulator, then sticky flag cleared
    beat(8'd100, 1'b0);
    beat(8'd100, 1'b1);
    check("t3_sum_n", out_sum_n, 8'hC8);
    check("t3_ovf_n", out_ovf_n, 1);
    check("t3_count_n", out_count_n, 2);
    check("t3_sum_w", out_sum_w, 200);
    check("t3_ovf_w", out_ovf_w, 0);
    next_cycle();
    beat(8'd1, 1'b1);
    check("t3b_sum_n", out_sum_n, 1);
    check("t3b_ovf_n", out_ovf_n, 0);
    next_cycle();

    // Count saturation on the 3-bit counter
    for (int i = 0; i < 9; i++) beat(8'd1, (i == 8));
    check("sat_count_n", out_count_n, 7);
    check("sat_count_w", out_count_w, 9);
    check("sat_sum_n", out_sum_n, 9);
    next_cycle();

    // Backpressure: result held, offered inputs ignored
    out_ready = 1'b0;
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid_w, 1);
      check("bp_sum", out_sum_w, 5);
      check("bp_in_ready", in_ready_w, 0);
      in_valid = 1'b1;
      in_data  = 8'd50;
      in_last  = 1'b1;
      next_cycle();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("bp_sum_end", out_sum_w, 5);
    out_ready = 1'b1;
    next_cycle();
    check("bp_in_ready_back", in_ready_w, 1);
    check("bp_valid_low", out_valid_w, 0);
    beat(8'd6, 1'b1);
    check("bp_next_sum", out_sum_w, 6);
    check("bp_next_count", out_count_w, 1);
    next_cycle();

    // Asynchronous reset in the middle of a frame
    beat(8'd7, 1'b0);
    beat(8'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_sum", out_sum_w, 0);
    check("mrst_count", out_count_w, 0);
    check("mrst_ovf", out_ovf_w, 0);
    check("mrst_valid", out_valid_w, 0);
    check("mrst_in_ready", in_ready_w, 1);
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'd4, 1'b1);
    check("mrst_next_sum", out_sum_w, 4);
    check("mrst_next_count", out_count_w, 1);
    next_cycle();

    // Randomized frames with valid/ready gaps
    total   = 0;
    run_w   = 0;
    run_n   = 0;
    ovf_w_m = 1'b0;
    ovf_n_m = 1'b0;
    pos     = 0;
    gen     = 0;
    len     = $urandom_range(1, 20);
    for (int cyc = 0; cyc < 40000 && done < 200; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid_w && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_sum_w", $signed(out_sum_w), e.sum_w);
          check("rand_count_w", out_count_w, e.cnt_w);
          check("rand_ovf_w", out_ovf_w, e.ovf_w);
          check("rand_valid_n", out_valid_n, 1);
          check("rand_sum_n", $signed(out_sum_n), e.sum_n);
          check("rand_count_n", out_count_n, e.cnt_n);
          check("rand_ovf_n", out_ovf_n, e.ovf_n);
        end
        done++;
      end
      if (gen < 200) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_last  = (pos == len - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (in_valid && in_ready_w) begin
        x = longint'($signed(in_data));
        total += x;
        if (out_of_range(run_w + x, 16)) ovf_w_m = 1'b1;
        if (out_of_range(run_n + x, 8)) ovf_n_m = 1'b1;
        run_w = wrap(run_w + x, 16);
        run_n = wrap(run_n + x, 8);
        pos++;
        if (in_last) begin
          e.sum_w = wrap(total, 16);
          e.sum_n = wrap(total, 8);
          e.cnt_w = (pos > 255) ? 255 : pos;
          e.cnt_n = (pos > 7) ? 7 : pos;
          e.ovf_w = ovf_w_m;
          e.ovf_n = ovf_n_m;
          exp_q.push_back(e);
          gen++;
          total   = 0;
          run_w   = 0;
          run_n   = 0;
          ovf_w_m = 1'b0;
          ovf_n_m = 1'b0;
          pos     = 0;
          len     = $urandom_range(1, 20);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rand_frames_done", done, 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
# frame_accumulator

- Sequential stage directly downstream of the combinational `n_bit_adder`.
- Accepts a framed stream of signed operands over a valid/ready handshake and sums each frame into a wider signed accumulator, one operand per cycle.
- Presents the frame total, operand count and a sticky signed-overflow flag on a valid/ready output port.
- Feeds result consumers such as the display/readback logic.

## Interface

Parameters:
- `N`, default 8: operand width in bits, signed.
- `ACC_W`, default 16: accumulator and result width, signed; must be ≥ N.
- `CNT_W`, default 8: operand-count width.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_data`/`in_last` are valid.
- `in_ready`, output, 1: block can accept an operand.
- `in_data`, input, N: signed operand.
- `in_last`, input, 1: this operand closes the frame.
- `out_valid`, output, 1: result fields are valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, ACC_W: signed frame total.
- `out_count`, output, CNT_W: operands in the frame.
- `out_ovf`, output, 1: signed overflow occurred at least once in the frame.

## Operation

States:
- ACC: `in_ready`=1, `out_valid`=0.
- HOLD: `in_ready`=0, `out_valid`=1.

Accept and accumulate:
- An input beat is accepted when `in_valid && in_ready`.
- On accept, `in_data` is sign-extended to ACC_W and added to `acc` with carry-in 0. The adder is a ripple chain.
- Overflow condition: both addends have the same sign and the result sign differs. On overflow, the sum wraps modulo 2^ACC_W and the sticky `ovf` bit is set.
- `cnt` increments on each accept and saturates at 2^CNT_W−1.

Transitions:
- ACC → HOLD: on an accept with `in_last`=1. The same edge loads `out_sum`/`out_count`/`out_ovf` with the updated values, including the last operand.
- HOLD → ACC: when `out_ready`=1. The same edge clears `acc`, `cnt` and `ovf`.

Output behaviour:
- Output fields are registered and stay stable throughout HOLD.
- Backpressure: `out_ready`=0 holds HOLD indefinitely, and no input is accepted meanwhile.
- A single-beat frame (`in_last` on the first operand) is legal: count 1, sum = sign-extended operand.
- `in_valid`=0 in ACC: state and accumulators unchanged.

## Timing

- Reset (asynchronous, any state, including mid-frame): state=ACC; `acc`, `cnt`, `ovf`=0; `in_ready`=1; `out_valid`=0; `out_sum`=0; `out_count`=0; `out_ovf`=0. A partial frame is discarded.
- Throughput: one operand per cycle within a frame.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Inter-frame gap: at least one cycle. `in_ready` is 0 during HOLD and returns to 1 the cycle after the output handshake.
- Within the ACC → HOLD → ACC loop there are no simultaneous input and output handshakes.
- Combinational adder path: `acc` register → ACC_W ripple → `acc` register, so it must close timing in one cycle.

## Structure

- Package `adder_pkg`:
  - state enum `acc_state_t` {ACC, HOLD};
  - default width constants `ADD_N`, `ADD_ACC_W`, `ADD_CNT_W`;
  - a sign-extension helper function.
- Sub-module: one instance of `n_bit_adder #(.n(ACC_W))`, with cin tied 0.
  - Overflow is derived from the operand and result MSBs in this block, not from `cout`.
- Everything else (FSM, count, sticky flag, output registers) lives in `frame_accumulator`.

## Test plan

- Reset, then frame 10, 8, 5 (last) with `out_ready`=1 → `out_valid` one cycle after the 5 beat, sum 23, count 3, ovf 0; `in_ready` back to 1 the next cycle.
- Signed frame −128, 127, −1 (last) → sum −2 (0xFFFE), count 3, ovf 0.
- With ACC_W=N=8: frame 100, 100 (last) → sum −56 (0xC8, wrapped), ovf 1. The next frame, 1 (last), gives sum 1, ovf 0 (sticky cleared).
- Backpressure: hold `out_ready`=0 for 5 cycles after a frame 2, 3 (last) → sum 5 stable, `in_ready`=0, offered inputs ignored. Release → next frame starts from 0.
- Assert `rst_n`=0 mid-frame after 7, 9 → all outputs 0 immediately. The frame 4 (last) after release yields sum 4, count 1.
- Random: 200 frames of random length 1–20 with random valid/ready gaps → scoreboard matches the wide-integer golden sum mod 2^ACC_W, count, and ovf per frame.
